// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period and parity helpers.
// Intended for reuse by a future receiver block.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } uart_state_t;

    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// A clear restarts the period so every state begins on a bit boundary.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // bit_done must not depend on clear: clear is derived from the FSM, which uses bit_done
    assign bit_done = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and sends it as a UART frame, LSB first.
// Outputs are registered from the next-state decode so they change cleanly on clock edges.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_q,
    output logic        fifo_rdreq,
    output logic        tx,
    output logic        busy,
    output logic [15:0] byte_cnt
);

    localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t state, state_nx;
    logic [7:0]  shift_reg, shift_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic        par_bit;
    logic        tx_nx, rdreq_nx, busy_nx;
    logic        bit_done, baud_clr, frame_done;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CPB)
    ) u_baud_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clr),
        .bit_done(bit_done)
    );

    always_comb begin
        state_nx   = state;
        shift_nx   = shift_reg;
        bit_idx_nx = bit_idx;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_en && !fifo_empty) state_nx = S_POP;
            end
            S_POP: begin
                state_nx = S_LATCH;
            end
            S_LATCH: begin
                shift_nx = fifo_q;
                state_nx = S_START;
            end
            S_START: begin
                if (bit_done) begin
                    bit_idx_nx = '0;
                    state_nx   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_nx = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_nx = '0;
                        state_nx   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) state_nx = S_STOP;
            end
            S_STOP: begin
                if (bit_done) begin
                    if (bit_idx == LAST_STOP) begin
                        bit_idx_nx = '0;
                        frame_done = 1'b1;
                        state_nx   = S_IDLE;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        baud_clr = (state_nx != state);
        rdreq_nx = (state_nx == S_POP);
        busy_nx  = (state_nx != S_IDLE);

        // Line level follows the state being entered, so tx is already valid in its first cycle
        case (state_nx)
            S_START:  tx_nx = 1'b0;
            S_DATA:   tx_nx = shift_nx[0];
            S_PARITY: tx_nx = par_bit;
            default:  tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            par_bit    <= 1'b0;
            tx         <= 1'b1;
            fifo_rdreq <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_reg  <= shift_nx;
            bit_idx    <= bit_idx_nx;
            tx         <= tx_nx;
            fifo_rdreq <= rdreq_nx;
            busy       <= busy_nx;
            if (state == S_LATCH) par_bit <= parity_bit(fifo_q, PARITY_ODD != 0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
        end else if (frame_done) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end

endmodule
